// File: rtl/dsp_add_pkg.sv
// Shared types and limits for the dsp_add_join operand join stage.
package dsp_add_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int WIDTH_MAX   = 48;
    localparam int COUNT_WIDTH = 32;

endpackage

// File: rtl/dsp_add_join_slot.sv
// One-entry operand holding register. Accepts a new operand whenever it is
// empty or is being drained in the same edge, so refill and drain can overlap.
module dsp_add_join_slot
    import dsp_add_pkg::*;
#(
    parameter int width = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             drain,
    output logic [width-1:0] out_data,
    output logic             out_full
);

    slot_state_t      r_state;
    logic [width-1:0] r_data;
    logic             w_ready;
    logic             w_load;

    assign w_ready = !reset && ((r_state == EMPTY) || drain);
    assign w_load  = in_valid && w_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else if (w_load) begin
            r_state <= FULL;
            r_data  <= in_data;
        end else if (drain) begin
            r_state <= EMPTY;
        end
    end

    assign in_ready = w_ready;
    assign out_data = r_data;
    assign out_full = (r_state == FULL);

endmodule

// File: rtl/dsp_add_join.sv
// Pairs A and B operand streams in arrival order and registers each pair in
// front of the combinational DSP48E2 adder. Define DSP_ADD_JOIN_SKID_EN to
// use a 2-entry skid output stage instead of a single output register.
module dsp_add_join
    import dsp_add_pkg::*;
#(
    parameter int width = 48
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [width-1:0]       a_data,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [width-1:0]       b_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    output logic [width-1:0]       out_a,
    output logic [width-1:0]       out_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] pair_count
);

    generate
        if (width < 1 || width > WIDTH_MAX) begin : g_bad_width
            $error("dsp_add_join: width must be in 1..48");
        end
    endgenerate

    logic             w_a_full;
    logic             w_b_full;
    logic [width-1:0] w_a_q;
    logic [width-1:0] w_b_q;
    logic             w_fire;
    logic             w_can_accept;
    logic             w_out_hs;

    logic [COUNT_WIDTH-1:0] r_pair_count;

    dsp_add_join_slot #(.width(width)) u_slot_a (
        .clock    (clock),
        .reset    (reset),
        .in_data  (a_data),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .drain    (w_fire),
        .out_data (w_a_q),
        .out_full (w_a_full)
    );

    dsp_add_join_slot #(.width(width)) u_slot_b (
        .clock    (clock),
        .reset    (reset),
        .in_data  (b_data),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .drain    (w_fire),
        .out_data (w_b_q),
        .out_full (w_b_full)
    );

    assign w_fire = w_a_full && w_b_full && w_can_accept;

`ifdef DSP_ADD_JOIN_SKID_EN
    // Head entry drives the outputs; the skid entry absorbs the pair that
    // fires in the same edge out_ready drops.
    logic             r_head_valid;
    logic [width-1:0] r_head_a;
    logic [width-1:0] r_head_b;
    logic             r_skid_valid;
    logic [width-1:0] r_skid_a;
    logic [width-1:0] r_skid_b;
    logic [1:0]       w_count;
    logic             w_pop;

    assign w_count      = {1'b0, r_head_valid} + {1'b0, r_skid_valid};
    assign w_can_accept = (w_count < 2'd2);
    assign w_pop        = r_head_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head_valid <= 1'b0;
            r_head_a     <= '0;
            r_head_b     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
        end else if (w_pop) begin
            if (r_skid_valid) begin
                r_head_a     <= r_skid_a;
                r_head_b     <= r_skid_b;
                r_skid_valid <= 1'b0;
            end else begin
                r_head_valid <= w_fire;
                if (w_fire) begin
                    r_head_a <= w_a_q;
                    r_head_b <= w_b_q;
                end
            end
        end else if (w_fire) begin
            if (!r_head_valid) begin
                r_head_valid <= 1'b1;
                r_head_a     <= w_a_q;
                r_head_b     <= w_b_q;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_a     <= w_a_q;
                r_skid_b     <= w_b_q;
            end
        end
    end

    assign out_valid = r_head_valid;
    assign out_a     = r_head_a;
    assign out_b     = r_head_b;
`else
    logic             r_out_valid;
    logic [width-1:0] r_out_a;
    logic [width-1:0] r_out_b;

    assign w_can_accept = !r_out_valid || out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_a_q;
            r_out_b     <= w_b_q;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
`endif

    assign w_out_hs = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pair_count <= '0;
        end else if (w_out_hs) begin
            r_pair_count <= r_pair_count + 1'b1;
        end
    end

    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_dsp_add_join.sv
// Directed and randomized checks of dsp_add_join pairing, latency, back-pressure,
// reset and pair_count wrap. Inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_dsp_add_join;

    localparam int W = 48;

    logic          clock;
    logic          reset;
    logic [W-1:0]  a_data;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  b_data;
    logic          b_valid;
    logic          b_ready;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   pair_count;

    int n_checks;
    int n_fail;
    logic [31:0] exp_count;

    dsp_add_join #(.width(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .a_data     (a_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_data     (b_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pair_count (pair_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_data = 48'd3; b_data = 48'd4; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b required 0 0", a_ready, b_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_a !== '0 || out_b !== '0 || pair_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b out_a=%0h out_b=%0h pair_count=%0d required 0 0 0 0",
                     out_valid, out_a, out_b, pair_count);
        end
        @(posedge clock); #1;
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        exp_count = 32'd0;
        $display("reset: done");
    endtask

    task automatic test_basic();
        @(posedge clock); #1;
        a_valid = 1'b1; a_data = 48'd5; b_valid = 1'b1; b_data = 48'd7; out_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: a_ready=%b b_ready=%b required 1 1", a_ready, b_ready);
        end
        @(posedge clock); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cycle1: out_valid=%b required 0", out_valid);
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b1 || out_a !== 48'd5 || out_b !== 48'd7 || pair_count !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_cycle2: out_valid=%b out_a=%0d out_b=%0d pair_count=%0d required 1 5 7 0",
                     out_valid, out_a, out_b, pair_count);
        end
        @(posedge clock); #1;
        @(negedge clock);
        exp_count = exp_count + 32'd1;
        n_checks++;
        if (pair_count !== exp_count || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cycle3: pair_count=%0d out_valid=%b required %0d 0", pair_count, out_valid, exp_count);
        end
        $display("basic: pair (5,7) pair_count=%0d", pair_count);
    endtask

    task automatic test_early_a();
        logic [W-1:0] ra [4];
        logic [W-1:0] rb [4];
        int rx;
        @(posedge clock); #1;
        out_ready = 1'b1; a_valid = 1'b1; a_data = 48'd1;
        @(negedge clock);
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL early_a_first_ready: a_ready=%b required 1", a_ready);
        end
        @(posedge clock); #1;
        a_data = 48'd2;
        for (int c = 0; c < 11; c++) begin
            @(negedge clock);
            n_checks++;
            if (a_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL early_a_hold: cycle %0d a_ready=%b required 0", c, a_ready);
            end
            if (c < 10) begin
                @(posedge clock); #1;
            end
        end
        @(posedge clock); #1;
        b_valid = 1'b1; b_data = 48'd10;
        @(negedge clock);
        n_checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_a_b10: a_ready=%b b_ready=%b required 0 1", a_ready, b_ready);
        end
        @(posedge clock); #1;
        b_data = 48'd20;
        @(negedge clock);
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL early_a_fire: a_ready=%b b_ready=%b required 1 1", a_ready, b_ready);
        end
        @(posedge clock); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        rx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (out_valid && out_ready && rx < 4) begin
                ra[rx] = out_a; rb[rx] = out_b; rx++;
            end
            @(posedge clock); #1;
        end
        n_checks++;
        if (rx !== 2) begin
            n_fail++;
            $display("FAIL early_a_count: pairs=%0d required 2", rx);
        end else begin
            n_checks++;
            if (ra[0] !== 48'd1 || rb[0] !== 48'd10 || ra[1] !== 48'd2 || rb[1] !== 48'd20) begin
                n_fail++;
                $display("FAIL early_a_order: got (%0d,%0d) (%0d,%0d) required (1,10) (2,20)",
                         ra[0], rb[0], ra[1], rb[1]);
            end
        end
        exp_count = exp_count + 32'd2;
        $display("early_a: %0d pairs collected", rx);
    endtask

    task automatic test_back_to_back();
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clock); #1;
            out_ready = 1'b1;
            if (cyc < 8) begin
                a_valid = 1'b1; a_data = 48'(100 + cyc);
                b_valid = 1'b1; b_data = 48'(200 + cyc);
            end else begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
            @(negedge clock);
            if (cyc < 8) begin
                n_checks++;
                if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready: cycle %0d a_ready=%b b_ready=%b required 1 1", cyc, a_ready, b_ready);
                end
            end
            if (cyc >= 2 && cyc < 10) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_a !== 48'(100 + cyc - 2) || out_b !== 48'(200 + cyc - 2)) begin
                    n_fail++;
                    $display("FAIL b2b_out: cycle %0d out_valid=%b out_a=%0d out_b=%0d required 1 %0d %0d",
                             cyc, out_valid, out_a, out_b, 100 + cyc - 2, 200 + cyc - 2);
                end
            end
            if (cyc == 11) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
                end
            end
        end
        exp_count = exp_count + 32'd8;
        n_checks++;
        if (pair_count !== exp_count) begin
            n_fail++;
            $display("FAIL b2b_count: pair_count=%0d required %0d", pair_count, exp_count);
        end
        $display("b2b: 8 pairs, pair_count=%0d", pair_count);
    endtask

    task automatic test_random();
        logic [W-1:0] av [100];
        logic [W-1:0] bv [100];
        int rx;
        for (int i = 0; i < 100; i++) begin
            av[i] = 48'({$urandom(), $urandom()});
            bv[i] = 48'({$urandom(), $urandom()});
        end
        rx = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int gap;
                    int guard;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clock); #1; a_valid = 1'b0;
                    end
                    @(posedge clock); #1;
                    a_valid = 1'b1; a_data = av[i];
                    @(negedge clock);
                    guard = 0;
                    while (!a_ready && guard < 2000) begin
                        @(posedge clock); #1; @(negedge clock); guard++;
                    end
                end
                @(posedge clock); #1; a_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    int gap;
                    int guard;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clock); #1; b_valid = 1'b0;
                    end
                    @(posedge clock); #1;
                    b_valid = 1'b1; b_data = bv[i];
                    @(negedge clock);
                    guard = 0;
                    while (!b_ready && guard < 2000) begin
                        @(posedge clock); #1; @(negedge clock); guard++;
                    end
                end
                @(posedge clock); #1; b_valid = 1'b0;
            end
            begin
                logic         prev_stall;
                logic [W-1:0] prev_a;
                logic [W-1:0] prev_b;
                int cyc;
                prev_stall = 1'b0; prev_a = '0; prev_b = '0; cyc = 0;
                while (rx < 100 && cyc < 4000) begin
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clock);
                    cyc++;
                    if (prev_stall) begin
                        n_checks++;
                        if (out_valid !== 1'b1 || out_a !== prev_a || out_b !== prev_b) begin
                            n_fail++;
                            $display("FAIL rand_stable: out_valid=%b out_a=%0h out_b=%0h required 1 %0h %0h",
                                     out_valid, out_a, out_b, prev_a, prev_b);
                        end
                    end
                    if (out_valid && out_ready) begin
                        n_checks++;
                        if (out_a !== av[rx] || out_b !== bv[rx]) begin
                            n_fail++;
                            $display("FAIL rand_pair: index %0d out_a=%0h out_b=%0h required %0h %0h",
                                     rx, out_a, out_b, av[rx], bv[rx]);
                        end
                        rx++;
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_a = out_a; prev_b = out_b;
                end
                n_checks++;
                if (rx != 100) begin
                    n_fail++;
                    $display("FAIL rand_timeout: received %0d pairs required 100", rx);
                end
            end
        join
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        exp_count = exp_count + 32'd100;
        n_checks++;
        if (out_valid !== 1'b0 || pair_count !== exp_count) begin
            n_fail++;
            $display("FAIL rand_end: out_valid=%b pair_count=%0d required 0 %0d", out_valid, pair_count, exp_count);
        end
        $display("random: %0d pairs scoreboarded, pair_count=%0d", rx, pair_count);
    endtask

    task automatic test_reset_mid();
        int rx;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        @(posedge clock); #1;
        out_ready = 1'b0;
        a_valid = 1'b1; a_data = 48'd11; b_valid = 1'b1; b_data = 48'd22;
        repeat (6) @(posedge clock);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_held: out_valid=%b required 1", out_valid);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || pair_count !== 32'd0 || out_a !== '0 || out_b !== '0) begin
            n_fail++;
            $display("FAIL rstmid_after: out_valid=%b pair_count=%0d out_a=%0h out_b=%0h required 0 0 0 0",
                     out_valid, pair_count, out_a, out_b);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 48'd33; b_valid = 1'b1; b_data = 48'd44;
        @(posedge clock); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        rx = 0; ra = '0; rb = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                if (rx == 0) begin
                    ra = out_a; rb = out_b;
                end
                rx++;
            end
            @(posedge clock); #1;
        end
        n_checks++;
        if (rx != 1 || ra !== 48'd33 || rb !== 48'd44) begin
            n_fail++;
            $display("FAIL rstmid_post: pairs=%0d first=(%0d,%0d) required 1 (33,44)", rx, ra, rb);
        end
        exp_count = 32'd1;
        $display("reset_mid: %0d post-reset pair(s)", rx);
    endtask

    task automatic test_wrap();
        int guard;
        @(negedge clock);
        force dut.r_pair_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_pair_count;
        @(posedge clock); #1;
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 48'hABC; b_valid = 1'b1; b_data = 48'hDEF;
        @(posedge clock); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clock);
        guard = 0;
        while (!(out_valid && out_ready) && guard < 20) begin
            @(posedge clock); #1; @(negedge clock); guard++;
        end
        n_checks++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL wrap_timeout: out_valid=%b required 1", out_valid);
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++;
        if (pair_count !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_count: pair_count=%0h required 0", pair_count);
        end
        $display("wrap: pair_count=%0h", pair_count);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_count = 32'd0;
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_early_a();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
